power_display: RTL and testbench

Downstream display stage for the calculator's `power` unit. It captures the 8-bit `result` on a load strobe and converts it to three BCD digits with a sequential shift-add-3 (double-dabble) engine, one shift per clock. It then drives a 4-digit, active-low, multiplexed seven-segment display with the committed value. The display keeps showing the previous value until a new conversion commits.

---
 rtl/power_display.sv | 126 ++++++++++++
 tb/tb_power_display.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/power_display.sv
// Captures an 8-bit value, converts it to BCD with a serial double-dabble engine,
// and drives a 4-digit multiplexed active-low 7-seg display. Option: POWER_DISPLAY_BLANK_EN.
module power_display #(
  parameter int REFRESH_DIV = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic [7:0] result_i,
  output logic       busy_o,
  output logic       done_o,
  output logic [3:0] an_o,
  output logic [6:0] seg_o
);
  typedef enum logic {IDLE, CONVERT} state_t;

  localparam logic [REFRESH_DIV-1:0] REF_ONE = 1;

  state_t                 state_q;
  logic [7:0]             bin_q, bin_d;
  logic [11:0]            bcd_q, bcd_d, adj;
  logic [2:0]             cnt_q;
  logic [3:0]             hun_q, ten_q, uni_q;
  logic [REFRESH_DIV-1:0] ref_q;
  logic                   busy_q, done_q;
  logic [3:0]             an_q, an_d;
  logic [6:0]             seg_q, seg_d;
  logic [1:0]             slot;
  logic                   blank_h, blank_t;

  function automatic logic [6:0] dec7(input logic [3:0] d);
    case (d)
      4'd0:    dec7 = 7'b1000000;
      4'd1:    dec7 = 7'b1111001;
      4'd2:    dec7 = 7'b0100100;
      4'd3:    dec7 = 7'b0110000;
      4'd4:    dec7 = 7'b0011001;
      4'd5:    dec7 = 7'b0010010;
      4'd6:    dec7 = 7'b0000010;
      4'd7:    dec7 = 7'b1111000;
      4'd8:    dec7 = 7'b0000000;
      4'd9:    dec7 = 7'b0010000;
      default: dec7 = 7'b1111111;
    endcase
  endfunction

  // Add-3 correction precedes each shift, so the final commit reads bcd_d directly.
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < 3; i++)
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    bcd_d = {adj[10:0], bin_q[7]};
    bin_d = {bin_q[6:0], 1'b0};
  end

`ifdef POWER_DISPLAY_BLANK_EN
  assign blank_h = (hun_q == 4'd0);
  assign blank_t = (hun_q == 4'd0) && (ten_q == 4'd0);
`else
  assign blank_h = 1'b0;
  assign blank_t = 1'b0;
`endif

  assign slot = ref_q[REFRESH_DIV-1 -: 2];

  always_comb begin
    an_d  = 4'b1111;
    seg_d = 7'b1111111;
    case (slot)
      2'd0: begin an_d = 4'b1110; seg_d = dec7(uni_q); end
      2'd1: if (!blank_t) begin an_d = 4'b1101; seg_d = dec7(ten_q); end
      2'd2: if (!blank_h) begin an_d = 4'b1011; seg_d = dec7(hun_q); end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      hun_q   <= '0;
      ten_q   <= '0;
      uni_q   <= '0;
      ref_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      an_q    <= 4'b1111;
      seg_q   <= 7'b1111111;
    end else begin
      ref_q  <= ref_q + REF_ONE;
      an_q   <= an_d;
      seg_q  <= seg_d;
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (load_i) begin
          state_q <= CONVERT;
          busy_q  <= 1'b1;
          bin_q   <= result_i;
          bcd_q   <= '0;
          cnt_q   <= '0;
        end
        CONVERT: begin
          bin_q <= bin_d;
          bcd_q <= bcd_d;
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            hun_q   <= bcd_d[11:8];
            ten_q   <= bcd_d[7:4];
            uni_q   <= bcd_d[3:0];
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign an_o   = an_q;
  assign seg_o  = seg_q;
endmodule

// File: tb/tb_power_display.sv
// Directed bench for power_display with REFRESH_DIV=4 (16-cycle refresh frame).
module tb_power_display;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load = 1'b0;
  logic [7:0] result = 8'd0;
  logic       busy, done;
  logic [3:0] an;
  logic [6:0] seg;

  int checks = 0;
  int errors = 0;

  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100;
  localparam logic [6:0] S5 = 7'b0010010, S6 = 7'b0000010, S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0010000;
`ifdef POWER_DISPLAY_BLANK_EN
  localparam logic [6:0] LZ = BLANK;
`else
  localparam logic [6:0] LZ = S0;
`endif

  power_display #(.REFRESH_DIV(4)) dut (
    .clk_i(clk), .rst_i(rst), .load_i(load), .result_i(result),
    .busy_o(busy), .done_o(done), .an_o(an), .seg_o(seg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string tag);
    for (int k = 0; k < 20; k++) begin
      if (done) break;
      step();
    end
    chk(tag, done, 1'b1);
  endtask

  // Observe one full refresh frame and record the segments shown in each slot.
  task automatic scan(input string tag, input logic [6:0] eu, input logic [6:0] et,
                      input logic [6:0] eh);
    logic [6:0] su, st, sh;
    int bad;
    su = BLANK; st = BLANK; sh = BLANK; bad = 0;
    for (int k = 0; k < 16; k++) begin
      step();
      case (an)
        4'b1110: su = seg;
        4'b1101: st = seg;
        4'b1011: sh = seg;
        4'b1111: if (seg !== BLANK) bad++;
        default: bad++;
      endcase
    end
    chk({tag, "_units"}, su, eu);
    chk({tag, "_tens"}, st, et);
    chk({tag, "_hund"}, sh, eh);
    chk({tag, "_anode"}, bad, 0);
  endtask

  task automatic load_val(input logic [7:0] v);
    result = v;
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  initial begin
    int cnt, dones, bad_succ, bad_run, wraps, run;
    logic [3:0] prev, exp_next;
    logic       seen_change;

    // Reset
    step(); step();
    chk("rst_an", an, 4'b1111);
    chk("rst_seg", seg, BLANK);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    rst = 1'b0;
    step();
    chk("first_an", an, 4'b1110);
    chk("first_seg", seg, S0);

    // 8 -> busy for exactly 8 cycles, single-cycle done
    load_val(8'd8);
    cnt = 0;
    while (busy && cnt < 20) begin step(); cnt++; end
    chk("busy_len", cnt, 8);
    chk("done_pulse", done, 1'b1);
    step();
    chk("done_clear", done, 1'b0);
    scan("v8", S8, LZ, LZ);

    // 255
    load_val(8'd255);
    wait_done("done_255");
    step();
    scan("v255", S5, S5, S2);

    // 196 with load held 12 cycles: accepted at N and N+9 only
    result = 8'd196;
    dones = 0;
    for (int i = 0; i < 30; i++) begin
      load = (i < 12);
      step();
      if (done) dones++;
      if (i == 8) chk("n8_idle", busy, 1'b0);
      if (i == 9) chk("n9_recapture", busy, 1'b1);
    end
    load = 1'b0;
    chk("held_dones", dones, 2);
    scan("v196", S6, S9, S1);

    // 2, with result changed to 99 after capture
    result = 8'd2;
    load = 1'b1;
    step();
    load = 1'b0;
    result = 8'd99;
    wait_done("done_2");
    step();
    scan("v2", S2, LZ, LZ);

    // 200 aborted by reset at N+4
    load_val(8'd200);
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_an", an, 4'b1111);
    step();
    chk("abort_first_an", an, 4'b1110);
    chk("abort_first_seg", seg, S0);
    dones = 0;
    for (int i = 0; i < 10; i++) begin step(); if (done) dones++; end
    chk("abort_nodone", dones, 0);
    scan("v0", S0, LZ, LZ);

    load_val(8'd100);
    wait_done("done_100");
    step();
    scan("v100", S0, S0, S1);

    // Refresh order and wrap over 2^4+4 cycles
    bad_succ = 0; bad_run = 0; wraps = 0; run = 0; seen_change = 1'b0;
    step();
    prev = an;
    run = 1;
    for (int k = 1; k < 20; k++) begin
      step();
      if (an === prev) run++;
      else begin
        case (prev)
          4'b1110: exp_next = 4'b1101;
          4'b1101: exp_next = 4'b1011;
          4'b1011: exp_next = 4'b1111;
          default: exp_next = 4'b1110;
        endcase
        if (an !== exp_next) bad_succ++;
        if (seen_change && run != 4) bad_run++;
        if (prev == 4'b1111 && an == 4'b1110) wraps++;
        seen_change = 1'b1;
        run = 1;
        prev = an;
      end
    end
    chk("ref_order", bad_succ, 0);
    chk("ref_slot_len", bad_run, 0);
    chk("ref_wrap", wraps, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
